seq_det_param: RTL

- Parametrised, runtime-programmable serial sequence detector; successor to the fixed "11" detector in the FSM block set.
- Samples one serial bit per clock and compares the most recent LEN bits against a loadable pattern.
- Supports overlapping and non-overlapping detection, a sample enable, and a saturating match counter.
- Sits directly on a serial data line; `out` feeds downstream control logic and `match_cnt` is read by status logic.

---
 rtl/fsm_pkg.sv | 31 +++
 rtl/sat_counter.sv | 43 ++++
 rtl/seq_det_param.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_pkg
//  Description : Shared definitions for the serial FSM block set: state
//                encodings, reset-time pattern defaults and the pattern
//                length clamp used on load.
//  Revision    : 1.0  initial release
// ============================================================================
package fsm_pkg;

  // Detector state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Pattern loaded at reset: "11", right-aligned
  localparam logic [31:0] DEF_PAT_C = 32'b11;
  localparam int          DEF_LEN_C = 2;

  // Lengths below 2 become 2; lengths above the history depth become the depth
  function automatic int unsigned clamp_len(input int unsigned req_len,
                                            input int unsigned max_len);
    int unsigned r;
    r = req_len;
    if (r < 2) r = 2;
    if (r > max_len) r = max_len;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. A clear on the
//                same edge as an increment leaves the count at 1 so that the
//                event coinciding with the clear is not lost.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear dominates, increment sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_param
//  Description : Runtime-programmable serial sequence detector. Shifts in one
//                bit per enabled clock and pulses `out` the cycle after the
//                most recent len bits equal the loaded pattern. Supports
//                overlapping / non-overlapping detection and a saturating
//                match counter.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_det_param
  import fsm_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
  parameter int               DEF_LEN = DEF_LEN_C,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam logic [LEN_W-1:0] C_FILL_MAX = LEN_W'(PAT_W);

  // The oldest bit of the PAT_W-deep window only ever appears in the
  // shifted-in view (hist_nx), so only PAT_W-1 bits need to be stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic [1:0]       state_q, state_d;
  logic             out_q,  out_d;

  logic [PAT_W-1:0] hist_nx;
  logic [LEN_W-1:0] fill_nx;
  logic [PAT_W-1:0] len_mask;
  logic             match;

  // Mask selecting the low len_q bits of the window and the pattern
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Shift/fill/match decision and state transitions
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    state_d = state_q;
    out_d   = 1'b0;
    match   = 1'b0;
    hist_nx = {hist_q, in};
    fill_nx = (fill_q == C_FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

    if (pat_load) begin
      // New pattern: the bit on this edge is discarded and detection restarts
      pat_d   = pat;
      len_d   = LEN_W'(clamp_len(32'(len), PAT_W));
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_IDLE;
    end else if (en) begin
      match  = (fill_nx >= len_q) &&
               ((hist_nx & len_mask) == (pat_q & len_mask));
      hist_d = hist_nx[PAT_W-2:0];
      out_d  = match;
      if (match && !overlap) begin
        // Non-overlapping: the next match needs len fresh bits
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        fill_d  = fill_nx;
        state_d = (fill_nx >= len_q) ? ST_RUN : ST_FILL;
      end
    end
  end

  // Detector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_cnt)
  );

  assign out   = out_q;
  assign armed = (state_q == ST_RUN);

endmodule
`default_nettype wire
